z80_busrq_arbiter: RTL and testbench

Shares the tv80s bus between up to N external bus masters (DMA, video fetch, debug loader) by sequencing the CPU `busrq_n`/`busak_n` handshake. It sits beside the `tv80s` instance and drives its `busrq_n` input. It grants exactly one requester at a time in round-robin order. It guarantees the CPU a minimum run window between tenures.

---
 rtl/z80_bus_pkg.sv | 21 ++
 rtl/z80_rr_picker.sv | 48 ++++
 rtl/z80_busrq_arbiter.sv | 173 +++++++++++++++++
 tb/tb_z80_busrq_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/z80_bus_pkg.sv
// Shared types and defaults for the tv80s bus-request arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package z80_bus_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        GRANT   = 2'd2,
        RELEASE = 2'd3
    } busarb_state_t;

    // Default minimum CPU run window between tenures, in clocks
    localparam int BUSARB_CPU_GAP  = 4;
    // Default tenure limit when the timeout feature is built in
    localparam int BUSARB_MAX_HOLD = 256;
    // Largest supported number of requesters
    localparam int BUSARB_MAX_REQ  = 8;

endpackage

// File: rtl/z80_rr_picker.sv
// Round-robin priority encoder: first set req bit at or after ptr, wrapping.
// Latency: combinational, zero cycles.
// Backpressure: none; pick is all-zero when no request is pending.
module z80_rr_picker
    import z80_bus_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] pick_oh,
    output logic [IW-1:0]    pick_idx
);

    localparam logic [N_REQ-1:0] PICK_ONE = {{(N_REQ-1){1'b0}}, 1'b1};

    logic [2*N_REQ-1:0] req2;
    logic [N_REQ-1:0]   rot;
    logic               found;
    int                 pos;

    // Rotate the request vector so that bit 0 is the requester at ptr
    assign req2 = {req, req};
    assign rot  = req2[ptr +: N_REQ];

    // Scan the rotated vector from the pointer and map back to an index
    always_comb begin
        found    = 1'b0;
        pos      = 0;
        pick_idx = '0;
        pick_oh  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                pos   = int'(ptr) + i;
            end
        end
        if (pos >= N_REQ) begin
            pos = pos - N_REQ;
        end
        pick_idx = IW'(pos);
        if (found) begin
            pick_oh = PICK_ONE << pick_idx;
        end
    end

endmodule

// File: rtl/z80_busrq_arbiter.sv
// Shares the tv80s bus among N_REQ masters via busrq_n/busak_n, round-robin, with a CPU gap.
// Latency: req->busrq_n low 1 clk; busak_n low->grant 1 clk; req drop->grant low 1 clk.
// Backpressure: REQ waits indefinitely for busak_n; BUSARB_TIMEOUT_EN adds a MAX_HOLD tenure cut.
module z80_busrq_arbiter
    import z80_bus_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int CPU_GAP  = BUSARB_CPU_GAP,
    parameter int MAX_HOLD = BUSARB_MAX_HOLD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic             busrq_n,
    input  logic             busak_n,
    output logic             preempt,
    output logic             busy
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int GW = $clog2(CPU_GAP + 1);

    if (N_REQ < 2 || N_REQ > BUSARB_MAX_REQ || CPU_GAP < 1 || MAX_HOLD < 1) begin : g_param_check
        $error("z80_busrq_arbiter: parameter out of range");
    end

    busarb_state_t    state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic             busrq_n_q, busrq_n_d;
    logic             preempt_q, preempt_d;
    logic             busy_q, busy_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic [N_REQ-1:0] pick_oh;
    logic [IW-1:0]    pick_idx;
    logic             hold_done;

    z80_rr_picker #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_picker (
        .req      (req),
        .ptr      (ptr_q),
        .pick_oh  (pick_oh),
        .pick_idx (pick_idx)
    );

`ifdef BUSARB_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);
    logic [HW-1:0] hold_q, hold_d;

    // Tenure counter: zero on GRANT entry, counts every clock spent in GRANT
    always_comb begin
        hold_d = '0;
        if (state_q == GRANT) begin
            hold_d = hold_q + 1'b1;
        end
    end

    // Tenure counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    // Last clock of a MAX_HOLD-long tenure
    assign hold_done = (state_q == GRANT) && (hold_q == HW'(MAX_HOLD - 1));
`else
    // Tenures are unbounded without the timeout feature
    assign hold_done = 1'b0;
`endif

    // Next-state and registered-output logic for the bus handshake
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        busrq_n_d = busrq_n_q;
        preempt_d = 1'b0;
        ptr_d     = ptr_q;
        gap_d     = gap_q;
        // The gap only elapses while the CPU actually owns the bus
        if (busak_n && (gap_q != '0)) begin
            gap_d = gap_q - 1'b1;
        end
        unique case (state_q)
            IDLE: begin
                grant_d   = '0;
                busrq_n_d = 1'b1;
                // A spurious busak_n low here is ignored: no request is in flight
                if ((req != '0) && (gap_q == '0)) begin
                    state_d   = REQ;
                    busrq_n_d = 1'b0;
                end
            end
            REQ: begin
                busrq_n_d = 1'b0;
                if (req == '0) begin
                    state_d   = RELEASE;
                    busrq_n_d = 1'b1;
                end else if (!busak_n) begin
                    // Winner picked from req as seen at the acknowledge edge
                    state_d = GRANT;
                    grant_d = pick_oh;
                    ptr_d   = (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
                end
            end
            GRANT: begin
                busrq_n_d = 1'b0;
                if (busak_n) begin
                    // CPU took the bus back (reset or protocol fault): drop everything
                    state_d   = IDLE;
                    grant_d   = '0;
                    busrq_n_d = 1'b1;
                end else if ((req & grant_q) == '0) begin
                    // Normal release takes priority over a coincident timeout
                    state_d   = RELEASE;
                    grant_d   = '0;
                    busrq_n_d = 1'b1;
                end else if (hold_done) begin
                    state_d   = RELEASE;
                    grant_d   = '0;
                    busrq_n_d = 1'b1;
                    preempt_d = 1'b1;
                end
            end
            RELEASE: begin
                grant_d   = '0;
                busrq_n_d = 1'b1;
                if (busak_n) begin
                    state_d = IDLE;
                    gap_d   = GW'(CPU_GAP);
                end
            end
            default: begin
                state_d   = IDLE;
                grant_d   = '0;
                busrq_n_d = 1'b1;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            busrq_n_q <= 1'b1;
            preempt_q <= 1'b0;
            busy_q    <= 1'b0;
            ptr_q     <= '0;
            gap_q     <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            busrq_n_q <= busrq_n_d;
            preempt_q <= preempt_d;
            busy_q    <= busy_d;
            ptr_q     <= ptr_d;
            gap_q     <= gap_d;
        end
    end

    assign grant   = grant_q;
    assign busrq_n = busrq_n_q;
    assign preempt = preempt_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_z80_busrq_arbiter.sv
// Directed bench for z80_busrq_arbiter; busak_n is driven by hand in place of a tv80s.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: acknowledge delays are modelled by holding busak_n high in REQ.
module tb_z80_busrq_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [3:0] grant;
    logic       busrq_n;
    logic       busak_n;
    logic       preempt;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int bad;
    int cnt;

    z80_busrq_arbiter #(
        .N_REQ    (4),
        .CPU_GAP  (4),
        .MAX_HOLD (256)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .grant   (grant),
        .busrq_n (busrq_n),
        .busak_n (busak_n),
        .preempt (preempt),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Enters with the FSM in REQ; CPU acks after 1 clock, master holds 10 clocks
    task automatic tenure(input logic [3:0] exp, input logic [3:0] req_after, input bit more);
        int n;
        tick();
        chk("rr_req_wait_busrq", 32'(busrq_n), 32'd0);
        chk("rr_req_wait_grant", 32'(grant), 32'd0);
        busak_n = 1'b0;
        tick();
        chk("rr_grant_order", 32'(grant), 32'(exp));
        repeat (9) tick();
        chk("rr_grant_hold", 32'(grant), 32'(exp));
        req = req & ~exp;
        tick();
        chk("rr_release_grant", 32'(grant), 32'd0);
        chk("rr_release_busrq", 32'(busrq_n), 32'd1);
        req     = req_after;
        busak_n = 1'b1;
        if (more) begin
            n = 0;
            while (busrq_n === 1'b1 && n < 20) begin
                tick();
                if (busrq_n === 1'b1) n++;
            end
            chk("rr_gap_min", 32'(n >= 4), 32'd1);
            chk("rr_gap_len", 32'(n), 32'd5);
        end else begin
            tick();
            chk("rr_final_idle", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        reset   = 1'b1;
        req     = 4'b0000;
        busak_n = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_busrq", 32'(busrq_n), 32'd1);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_preempt", 32'(preempt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Single requester
        req = 4'b0001;
        tick();
        chk("s1_busrq_low", 32'(busrq_n), 32'd0);
        chk("s1_no_grant_yet", 32'(grant), 32'd0);
        chk("s1_busy", 32'(busy), 32'd1);
        tick();
        chk("s1_wait_ack", 32'(grant), 32'd0);
        busak_n = 1'b0;
        tick();
        chk("s1_grant", 32'(grant), 32'b0001);
        req = 4'b0000;
        tick();
        chk("s1_drop_grant", 32'(grant), 32'd0);
        chk("s1_drop_busrq", 32'(busrq_n), 32'd1);
        chk("s1_release_busy", 32'(busy), 32'd1);
        busak_n = 1'b1;
        tick();
        chk("s1_idle", 32'(busy), 32'd0);

        // Round-robin from a fresh pointer with req=1011
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req   = 4'b1011;
        tick();
        chk("rr_start_busrq", 32'(busrq_n), 32'd0);
        tenure(4'b0001, 4'b1011, 1'b1);
        tenure(4'b0010, 4'b1011, 1'b1);
        tenure(4'b1000, 4'b1011, 1'b1);
        tenure(4'b0001, 4'b0000, 1'b0);

        // Abort in REQ: one-clock request pulse
        repeat (6) tick();
        req = 4'b0001;
        tick();
        chk("abort_busrq_low", 32'(busrq_n), 32'd0);
        req = 4'b0000;
        tick();
        chk("abort_busrq_high", 32'(busrq_n), 32'd1);
        chk("abort_no_grant", 32'(grant), 32'd0);
        tick();
        chk("abort_idle", 32'(busy), 32'd0);
        chk("abort_no_grant2", 32'(grant), 32'd0);

        // Spurious acknowledge in IDLE
        busak_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("spur_grant", 32'(grant), 32'd0);
            chk("spur_busrq", 32'(busrq_n), 32'd1);
        end
        busak_n = 1'b1;
        repeat (6) tick();

        // Reset mid-tenure; pointer is 1 after the last round-robin winner
        req = 4'b0101;
        tick();
        chk("rst_mid_busrq", 32'(busrq_n), 32'd0);
        busak_n = 1'b0;
        tick();
        chk("rst_mid_grant", 32'(grant), 32'b0100);
        reset = 1'b1;
        tick();
        chk("rst_mid_grant0", 32'(grant), 32'd0);
        chk("rst_mid_busrq1", 32'(busrq_n), 32'd1);
        chk("rst_mid_busy0", 32'(busy), 32'd0);
        chk("rst_mid_preempt", 32'(preempt), 32'd0);
        repeat (2) tick();
        reset   = 1'b0;
        busak_n = 1'b1;
        req     = 4'b0000;
        tick();

        // Pointer back at 0: req=1010 must pick bit 1
        req = 4'b1010;
        tick();
        chk("ptr_rst_busrq", 32'(busrq_n), 32'd0);
        busak_n = 1'b0;
        tick();
        chk("ptr_rst_grant", 32'(grant), 32'b0010);

`ifdef BUSARB_TIMEOUT_EN
        cnt = 0;
        while (preempt !== 1'b1 && cnt < 1000) begin
            if (grant === 4'b0010) cnt++;
            tick();
        end
        chk("to_hold_len", 32'(cnt), 32'd256);
        chk("to_grant_drop", 32'(grant), 32'd0);
        req     = 4'b0000;
        busak_n = 1'b1;
        repeat (2) tick();
        chk("to_idle", 32'(busy), 32'd0);
`else
        bad = 0;
        repeat (1000) begin
            tick();
            if (grant !== 4'b0010 || preempt !== 1'b0) bad++;
        end
        chk("hold_persist", 32'(bad), 32'd0);

        // CPU drops busak_n mid-tenure: straight back to IDLE
        busak_n = 1'b1;
        tick();
        chk("ack_loss_grant", 32'(grant), 32'd0);
        chk("ack_loss_busrq", 32'(busrq_n), 32'd1);
        chk("ack_loss_busy", 32'(busy), 32'd0);
        req = 4'b0000;
        repeat (2) tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
